// File: rtl/flash_audio_streamer_pkg.sv
// Shared types and widths for the flash-to-codec audio streaming path.
package flash_audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_PUSH1} fetch_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SEND, C_ACK} codec_state_t;
endpackage

// File: rtl/flash_audio_streamer_if.sv
// Flash Avalon-MM read port plus codec write handshake, grouped as one bundle.
interface flash_audio_streamer_if #(parameter int ADDR_W = 23);
  import flash_audio_pkg::*;

  logic                flash_mem_read;
  logic [ADDR_W-1:0]   flash_mem_address;
  logic                flash_mem_waitrequest;
  logic [WORD_W-1:0]   flash_mem_readdata;
  logic                flash_mem_readdatavalid;
  logic                write_ready;
  logic                write_s;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;

  modport master (
    output flash_mem_read, flash_mem_address,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    input  write_ready,
    output write_s, writedata_left, writedata_right
  );

  modport slave (
    input  flash_mem_read, flash_mem_address,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid,
    output write_ready,
    input  write_s, writedata_left, writedata_right
  );
endinterface

// File: rtl/flash_audio_streamer_fifo.sv
// Synchronous show-ahead FIFO; push on full and pop on empty are ignored.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  // Pointers are exactly AW bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/flash_audio_streamer.sv
// Prefetches 32-bit flash words over a wrapping address window, splits them into
// two attenuated mono samples and feeds the codec through a small sample FIFO.
module flash_audio_streamer
  import flash_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 23,
  parameter int SHIFT      = 6
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 play,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W-1:0]    end_addr,
  flash_audio_streamer_if.master bus,
  output logic                 wrap,
  output logic                 underrun,
  output logic                 cfg_err
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t        fstate_q, fstate_d;
  codec_state_t        cstate_q, cstate_d;
  logic                play_q;
  logic                cfg_err_q, cfg_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, start_q, start_d, end_q, end_d;
  logic [SAMPLE_W-1:0] hi_q, hi_d, data_q, data_d;
  logic                write_s_q, write_s_d;

  logic                push, pop, fifo_full, fifo_empty, free_ok;
  logic [SAMPLE_W-1:0] push_dat, fifo_dout;
  logic [CNT_W-1:0]    fifo_count;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (push_dat),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A word always lands as two pushes, so only start a fetch with two free slots.
  assign free_ok   = !fifo_full && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
  assign cfg_err_d = play && (end_addr < start_addr);

  always_comb begin
    fstate_d = fstate_q;
    addr_d   = addr_q;
    start_d  = start_q;
    end_d    = end_q;
    hi_d     = hi_q;
    push     = 1'b0;
    push_dat = hi_q;
    wrap     = 1'b0;
    case (fstate_q)
      F_IDLE: begin
        if (play && !play_q && !cfg_err_d) begin
          start_d = start_addr;
          end_d   = end_addr;
          addr_d  = start_addr;
        end
        if (play && !cfg_err_q && !cfg_err_d && free_ok) fstate_d = F_REQ;
      end
      F_REQ: if (!bus.flash_mem_waitrequest) fstate_d = F_WAIT;
      F_WAIT: begin
        if (bus.flash_mem_readdatavalid) begin
          hi_d     = bus.flash_mem_readdata[WORD_W-1:SAMPLE_W];
          push     = 1'b1;
          push_dat = bus.flash_mem_readdata[SAMPLE_W-1:0];
          fstate_d = F_PUSH1;
        end
      end
      F_PUSH1: begin
        push     = 1'b1;
        push_dat = hi_q;
        wrap     = (addr_q == end_q);
        addr_d   = (addr_q == end_q) ? start_q : addr_q + 1'b1;
        fstate_d = F_IDLE;
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  always_comb begin
    cstate_d  = cstate_q;
    data_d    = data_q;
    write_s_d = write_s_q;
    pop       = 1'b0;
    underrun  = 1'b0;
    case (cstate_q)
      C_IDLE: begin
        write_s_d = 1'b0;
        if (bus.write_ready && !fifo_empty) begin
          pop      = 1'b1;
          data_d   = $signed(fifo_dout) >>> SHIFT;
          cstate_d = C_SEND;
        end else if (bus.write_ready && play) begin
          underrun = 1'b1;
        end
      end
      C_SEND: begin
        write_s_d = 1'b1;
        cstate_d  = C_ACK;
      end
      C_ACK: begin
        if (!bus.write_ready) begin
          write_s_d = 1'b0;
          cstate_d  = C_IDLE;
        end
      end
      default: cstate_d = C_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fstate_q  <= F_IDLE;
      cstate_q  <= C_IDLE;
      play_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      addr_q    <= '0;
      start_q   <= '0;
      end_q     <= '0;
      hi_q      <= '0;
      data_q    <= '0;
      write_s_q <= 1'b0;
    end else begin
      fstate_q  <= fstate_d;
      cstate_q  <= cstate_d;
      play_q    <= play;
      cfg_err_q <= cfg_err_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      end_q     <= end_d;
      hi_q      <= hi_d;
      data_q    <= data_d;
      write_s_q <= write_s_d;
    end
  end

  assign bus.flash_mem_read    = (fstate_q == F_REQ);
  assign bus.flash_mem_address = addr_q;
  assign bus.write_s           = write_s_q;
  assign bus.writedata_left    = data_q;
  assign bus.writedata_right   = data_q;
  assign cfg_err               = cfg_err_q;
endmodule

// File: tb/tb_flash_audio_streamer.sv
// Directed bench: flash and codec models around flash_audio_streamer, window 0x10-0x11.
`timescale 1ns/1ps
module tb_flash_audio_streamer;
  import flash_audio_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic        wrap, underrun, cfg_err;

  flash_audio_streamer_if #(.ADDR_W(23)) bus();

  flash_audio_streamer #(.FIFO_DEPTH(8), .ADDR_W(23), .SHIFT(6)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .play       (play),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .bus        (bus),
    .wrap       (wrap),
    .underrun   (underrun),
    .cfg_err    (cfg_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;

  // Hand-computed codec samples for words 0x8000_7FC0 (addr 0x10) and 0x0040_FFC0 (addr 0x11).
  logic [15:0] pat [4] = '{16'h01FF, 16'hFE00, 16'hFFFF, 16'h0001};

  int          ws_target = 2, lat = 1, ws_cnt = 0, pend = -1, req_len = 0;
  logic [22:0] pend_addr = '0;
  logic [22:0] acc_q [$];
  int          req_len_q [$];
  logic [15:0] cap_q [$];
  int          lr_bad = 0, ready_dly = 0;
  bit          codec_hold = 1'b0;
  logic        ws_prev = 1'b0;
  int          wrap_cnt = 0, wrap_bad = 0, und_cnt = 0, fill_viol = 0, max_cnt = 0, rd_cycles = 0;

  function automatic logic [31:0] flash_word(input logic [22:0] a);
    case (a)
      23'h10:  return 32'h8000_7FC0;
      23'h11:  return 32'h0040_FFC0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Flash model: ws_target wait states per request, data lat cycles after acceptance.
  initial begin
    bus.flash_mem_waitrequest   = 1'b0;
    bus.flash_mem_readdata      = '0;
    bus.flash_mem_readdatavalid = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      bus.flash_mem_readdatavalid = 1'b0;
      if (pend > 0) pend--;
      if (pend == 0) begin
        bus.flash_mem_readdata      = flash_word(pend_addr);
        bus.flash_mem_readdatavalid = 1'b1;
        pend = -1;
      end
      if (bus.flash_mem_read === 1'b1) begin
        req_len++;
        if (ws_cnt < ws_target) begin
          bus.flash_mem_waitrequest = 1'b1;
          ws_cnt++;
        end else begin
          bus.flash_mem_waitrequest = 1'b0;
          ws_cnt = 0;
          acc_q.push_back(bus.flash_mem_address);
          req_len_q.push_back(req_len);
          req_len = 0;
          pend = lat;
          pend_addr = bus.flash_mem_address;
        end
      end else begin
        bus.flash_mem_waitrequest = 1'b0;
      end
    end
  end

  // Codec model: take a sample on each write_s rise, then drop ready for two cycles.
  initial begin
    bus.write_ready = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (bus.write_s === 1'b1 && ws_prev !== 1'b1) begin
        cap_q.push_back(bus.writedata_left);
        if (bus.writedata_left !== bus.writedata_right) lr_bad++;
        bus.write_ready = 1'b0;
        ready_dly = 2;
      end else if (codec_hold) begin
        bus.write_ready = 1'b0;
      end else if (ready_dly > 0) begin
        ready_dly--;
        bus.write_ready = (ready_dly == 0);
      end else begin
        bus.write_ready = 1'b1;
      end
      ws_prev = bus.write_s;
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (wrap === 1'b1) begin
        wrap_cnt++;
        if (bus.flash_mem_address !== end_addr) wrap_bad++;
      end
      if (underrun === 1'b1) und_cnt++;
      if (bus.flash_mem_read === 1'b1) begin
        rd_cycles++;
        if (dut.u_fifo.count > 4'd6) fill_viol++;
      end
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    play  = 1'b0;
    cycles(3);
    total++;
    if ({bus.flash_mem_read, bus.write_s, wrap, underrun, cfg_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=00000",
               {bus.flash_mem_read, bus.write_s, wrap, underrun, cfg_err});
    end
    total++;
    if (bus.flash_mem_address !== 23'h0) begin
      bad++; $display("FAIL reset_addr got=%0h want=0", bus.flash_mem_address);
    end
    total++;
    if ({bus.writedata_left, bus.writedata_right} !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%0h/%0h want=0/0", bus.writedata_left, bus.writedata_right);
    end
    total++;
    if (dut.u_fifo.count !== 4'd0) begin
      bad++; $display("FAIL reset_fifo got=%0d want=0", dut.u_fifo.count);
    end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_first_word;
    int n;
    start_addr = 23'h10; end_addr = 23'h11; ws_target = 2; lat = 1;
    acc_q.delete(); req_len_q.delete(); cap_q.delete();
    lr_bad = 0; wrap_cnt = 0; wrap_bad = 0;
    play = 1'b1;
    n = 0;
    while (cap_q.size() < 2 && n < 300) begin cycles(1); n++; end
    total++;
    if (n >= 300) begin bad++; $display("FAIL first_timeout got=%0d samples want=2", cap_q.size()); end
    total++;
    if (acc_q[0] !== 23'h10) begin bad++; $display("FAIL first_addr got=%0h want=10", acc_q[0]); end
    total++;
    if (req_len_q[0] !== 3) begin bad++; $display("FAIL first_read_len got=%0d want=3", req_len_q[0]); end
    total++;
    if (cap_q[0] !== 16'h01FF) begin bad++; $display("FAIL first_lo got=%0h want=01ff", cap_q[0]); end
    total++;
    if (cap_q[1] !== 16'hFE00) begin bad++; $display("FAIL first_hi got=%0h want=fe00", cap_q[1]); end
    total++;
    if (lr_bad !== 0) begin bad++; $display("FAIL first_mono got=%0d want=0", lr_bad); end
  endtask

  task automatic test_wrap;
    int n;
    n = 0;
    while (acc_q.size() < 5 && n < 500) begin cycles(1); n++; end
    total++;
    if (n >= 500) begin bad++; $display("FAIL wrap_timeout got=%0d words want=5", acc_q.size()); end
    total++;
    if (wrap_cnt !== 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", wrap_cnt); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (acc_q[i] !== ((i % 2 == 1) ? 23'h11 : 23'h10)) begin
        bad++; $display("FAIL wrap_seq[%0d] got=%0h want=%0h", i, acc_q[i], (i % 2 == 1) ? 23'h11 : 23'h10);
      end
    end
    play = 1'b0;
    cycles(150);
    total++;
    if (wrap_bad !== 0) begin bad++; $display("FAIL wrap_cycle got=%0d off-address pulses want=0", wrap_bad); end
    total++;
    if (cap_q.size() !== 2 * acc_q.size()) begin
      bad++; $display("FAIL stream_len got=%0d want=%0d", cap_q.size(), 2 * acc_q.size());
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== pat[i % 4]) begin bad++; $display("FAIL stream[%0d] got=%0h want=%0h", i, cap_q[i], pat[i % 4]); end
    end
    total++;
    if (lr_bad !== 0) begin bad++; $display("FAIL stream_mono got=%0d want=0", lr_bad); end
  endtask

  task automatic test_backpressure;
    acc_q.delete(); cap_q.delete();
    codec_hold = 1'b1; fill_viol = 0; max_cnt = 0;
    cycles(2);
    play = 1'b1;
    cycles(200);
    total++;
    if (dut.u_fifo.count !== 4'd8) begin bad++; $display("FAIL bp_fill got=%0d want=8", dut.u_fifo.count); end
    total++;
    if (fill_viol !== 0 || bus.flash_mem_read !== 1'b0) begin
      bad++; $display("FAIL bp_read_gate got=%0d/%b want=0/0", fill_viol, bus.flash_mem_read);
    end
    total++;
    if (acc_q.size() !== 4) begin bad++; $display("FAIL bp_words got=%0d want=4", acc_q.size()); end
    codec_hold = 1'b0;
    play = 1'b0;
    cycles(150);
    total++;
    if (cap_q.size() !== 8) begin bad++; $display("FAIL bp_drain got=%0d want=8", cap_q.size()); end
    for (int i = 0; i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== pat[i % 4]) begin bad++; $display("FAIL bp[%0d] got=%0h want=%0h", i, cap_q[i], pat[i % 4]); end
    end
  endtask

  task automatic test_stop_in_req;
    int n;
    acc_q.delete(); req_len_q.delete(); cap_q.delete();
    ws_target = 10;
    play = 1'b1;
    n = 0;
    while (bus.flash_mem_read !== 1'b1 && n < 50) begin cycles(1); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL stop_req_timeout got=%0d want=<50", n); end
    cycles(2);
    play = 1'b0;
    cycles(1);
    und_cnt = 0;
    cycles(150);
    total++;
    if (acc_q.size() !== 1) begin bad++; $display("FAIL stop_words got=%0d want=1", acc_q.size()); end
    total++;
    if (req_len_q[0] !== 11) begin bad++; $display("FAIL stop_read_len got=%0d want=11", req_len_q[0]); end
    total++;
    if (cap_q.size() !== 2 || cap_q[0] !== 16'h01FF || cap_q[1] !== 16'hFE00) begin
      bad++; $display("FAIL stop_samples got=%0d:%0h,%0h want=2:1ff,fe00", cap_q.size(), cap_q[0], cap_q[1]);
    end
    total++;
    if (und_cnt !== 0) begin bad++; $display("FAIL stop_underrun got=%0d want=0", und_cnt); end
    ws_target = 2;
  endtask

  task automatic test_underrun;
    acc_q.delete(); cap_q.delete();
    ws_target = 50; und_cnt = 0;
    play = 1'b1;
    cycles(30);
    total++;
    if (und_cnt < 25) begin bad++; $display("FAIL underrun_pulses got=%0d want>=25", und_cnt); end
    total++;
    if (cap_q.size() !== 0) begin bad++; $display("FAIL underrun_no_write got=%0d want=0", cap_q.size()); end
    play = 1'b0;
    cycles(150);
    total++;
    if (acc_q.size() !== 1 || cap_q.size() !== 2 || cap_q[0] !== 16'h01FF || cap_q[1] !== 16'hFE00) begin
      bad++; $display("FAIL underrun_recover got=%0d/%0d:%0h,%0h want=1/2:1ff,fe00",
                      acc_q.size(), cap_q.size(), cap_q[0], cap_q[1]);
    end
    ws_target = 2;
  endtask

  task automatic test_cfg_err;
    start_addr = 23'h20; end_addr = 23'h1F;
    rd_cycles = 0;
    play = 1'b1;
    cycles(20);
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_set got=%b want=1", cfg_err); end
    total++;
    if (rd_cycles !== 0) begin bad++; $display("FAIL cfg_err_reads got=%0d want=0", rd_cycles); end
    play = 1'b0;
    cycles(2);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b want=0", cfg_err); end
  endtask

  task automatic test_reset_mid;
    int n;
    start_addr = 23'h10; end_addr = 23'h11;
    lat = 6; ws_target = 0;
    acc_q.delete(); cap_q.delete();
    play = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin cycles(1); n++; end
    cycles(1);
    total++;
    if (dut.fstate_q !== F_WAIT) begin bad++; $display("FAIL rst_mid_state got=%0d want=%0d", dut.fstate_q, F_WAIT); end
    reset = 1'b1;
    play  = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(10);
    total++;
    if ({bus.flash_mem_read, bus.write_s, wrap, underrun, cfg_err} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_strobes got=%b want=00000",
                      {bus.flash_mem_read, bus.write_s, wrap, underrun, cfg_err});
    end
    total++;
    if (bus.flash_mem_address !== 23'h0 || bus.writedata_left !== 16'h0 || bus.writedata_right !== 16'h0) begin
      bad++; $display("FAIL rst_mid_regs got=%0h/%0h/%0h want=0/0/0",
                      bus.flash_mem_address, bus.writedata_left, bus.writedata_right);
    end
    total++;
    if (dut.u_fifo.count !== 4'd0 || cap_q.size() !== 0) begin
      bad++; $display("FAIL rst_mid_fifo got=%0d/%0d want=0/0", dut.u_fifo.count, cap_q.size());
    end
    lat = 1; ws_target = 2;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_wrap();
    test_backpressure();
    test_stop_in_req();
    test_underrun();
    test_cfg_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
